bsg_gateway_clk_div_multi: RTL and testbench
============================================

Name: bsg_gateway_clk_div_multi

Overview:
Runtime-programmable multi-channel clock divider with a lock sequencer. It is driven by one fast gateway clock (a PLL output on a BUFG) and produces num_channels_p divided clocks plus one-cycle strobes. Divide ratios change glitch-free at period boundaries. All channels stay gated until the PLL lock has been stable for a programmed wait. It replaces fixed PLL CLKOUTn divides for slow/auxiliary domains (tag, io master, core-test) whose ratio must change without a rebuild.

Parameters:
num_channels_p, 4, number of divided clock channels (1..16)
div_width_p, 8, width of divide value; max divide 2^div_width_p-1
init_div_p, 4, divide value loaded into every channel at reset (0 or >=2)
lock_wait_p, 1024, cycles synced pll_locked_i must stay high before locked_o asserts (>=1)

Ports:
clk_i  in  1  fast source clock; sole clock
reset_i  in  1  synchronous, active-high reset
pll_locked_i  in  1  asynchronous PLL LOCKED; double-flop synchronized internally
align_i  in  1  one-cycle pulse; restarts all enabled channel counters together
cfg_v_i  in  1  config write valid
cfg_chan_i  in  $clog2(num_channels_p) (min 1)  target channel
cfg_div_i  in  div_width_p  new divide; 0 = disable channel
cfg_ready_o  out  1  target channel pending slot empty; combinational from cfg_chan_i
cfg_error_o  out  1  one-cycle pulse: accepted write had cfg_div_i==1 (discarded)
clk_o  out  num_channels_p  divided clocks, registered
strobe_o  out  num_channels_p  one-cycle pulse coincident with each clk_o rising edge, registered
locked_o  out  1  lock sequencer done; channels running

Behaviour:
- Reset, synchronous: clk_o=0, strobe_o=0, locked_o=0, cfg_error_o=0, lock counter=0, sync flops=0. Every div_r=init_div_p, cnt_r=0, pend_v_r=0.
- Lock: lk_s is pll_locked_i after 2 flops. While lk_s=1 and the counter is below lock_wait_p, the counter increments. locked_o registers 1 in the cycle after the counter reaches lock_wait_p. If lk_s=0, the counter clears and locked_o drops to 0 on the next edge.
- Total assertion latency is lock_wait_p+3 clk_i edges after pll_locked_i rises. A loss of lock is reflected within 3 edges.
- While locked_o=0, all channels are frozen: cnt_r=0, clk_o=0, strobe_o=0. Config writes are still accepted.
- On the first cycle with locked_o=1, every enabled channel emits clk_o=1 and strobe_o=1 on the same edge (aligned start).
- Channel with D=div_r>=2:
  - cnt_r counts 0..D-1 and wraps.
  - Registered outputs: clk_o=(cnt_next < (D+1)>>1) and strobe_o=(cnt_next==0).
  - Result: high for ceil(D/2) cycles and low for floor(D/2) cycles; odd D has its high phase one cycle longer.
- Channel with D=0: cnt_r=0, clk_o=0, strobe_o=0.
- Config handshake: a write is accepted when cfg_v_i & cfg_ready_o.
  - Accepted div==1: dropped, cfg_error_o pulses on the next cycle, no state change.
  - Any other accepted value: stored in pend_r and sets pend_v_r.
  - While pend_v_r=1, cfg_ready_o=0 for that channel. There is no overwrite.
- Apply rule: pend_r moves into div_r and pend_v_r clears on the cycle when the next count wraps to 0, i.e. cnt_r==D-1 with locked_o=1. It also applies immediately on the next cycle if D==0 or locked_o==0.
  - The first cycle under the new divide is a rising edge, cnt=0, strobe=1. No runt pulse is possible.
  - From enabled to disabled: clk_o goes 0 at the wrap point and no strobe is emitted.
- align_i (ignored while locked_o=0): every enabled channel forces cnt_next=0, giving clk_o=1 and strobe_o=1 next edge.
  - Any pending value is applied in the same cycle.
  - align_i takes priority over a normal count advance.
- Write accepted in the same cycle its channel applies a previous pending value: not possible, because ready was low.
- Reset mid-operation: all state returns to reset values next edge. Pending writes are lost.

Decomposition:
- Package bsg_gateway_clk_pkg:
  - typedefs for div value (logic [div_width_p-1:0]) and channel index
  - localparams for the sync depth (2) and disable code (0)
- Sub-module bsg_gateway_clk_div_chan: one channel containing cnt_r, div_r, pend_r/pend_v_r, apply rule and output flops.
  - Inputs: en (locked_o), align, wr_v, wr_div.
  - Outputs: ready, clk, strobe.
- The top holds the lock synchronizer/counter, the cfg demux, error pulse logic, and the generate loop of channels.

Test Plan:
- reset, lock_wait_p=16, raise pll_locked_i at t0 -> locked_o=1 at t0+19 edges. In the same cycle all 4 clk_o/strobe_o =1. Period 4, high 2 cycles.
- Running D=4: write ch1 div=5 mid-period -> cfg_ready_o(ch1)=0 until the wrap. Then ch1 period 5, high 3 low 2. Strobe on each rise, no short pulse.
- Write ch2 div=1 -> cfg_error_o pulses once, ch2 unchanged at D=4. Write ch2 div=0 -> clk_o[2] low from the wrap, no strobes.
- ch0 D=3, ch3 D=7 running, pulse align_i -> both have strobe_o=1 on the next edge. Phases re-aligned: next common rise 21 cycles later.
- Drop pll_locked_i while running -> locked_o=0 within 3 edges, all clk_o=0. Re-raise -> locked_o asserts after lock_wait_p+3, channels restart aligned.
- Assert reset_i with a pending write -> next edge: outputs 0, div_r=init_div_p, pend cleared, cfg_ready_o=1.

Source files
------------

// File: rtl/bsg_gateway_clk_div_multi_pkg.sv
// Shared definitions for the gateway multi-channel clock divider.
// Holds the synchronizer depth, the "channel disabled" divide code, the
// default-build typedefs for divide values and channel indices, and small
// helpers used for sizing the config channel index and the high phase.
package bsg_gateway_clk_pkg;

  // Number of flops used to bring the asynchronous PLL LOCKED into clk_i.
  localparam int sync_depth_lp = 2;

  // A divide value of zero parks the channel low with no strobes.
  localparam int div_disable_lp = 0;

  // Geometry of the default build; the typedefs below follow it.
  localparam int div_width_default_lp    = 8;
  localparam int num_channels_default_lp = 4;

  // Width of a channel index; a single channel still gets a 1-bit index.
  function automatic int unsigned chan_width(input int unsigned num_channels);
    if (num_channels > 32'd1) begin
      return $clog2(num_channels);
    end else begin
      return 32'd1;
    end
  endfunction

  // Number of high cycles in one period of divide d: ceil(d/2).
  function automatic logic [31:0] high_phase_len(input logic [31:0] d);
    return (d + 32'd1) >> 1'b1;
  endfunction

  typedef logic [div_width_default_lp-1:0]                       div_t;
  typedef logic [chan_width(num_channels_default_lp)-1:0]        chan_idx_t;

endpackage

// File: rtl/bsg_gateway_clk_div_multi_if.sv
// Config write port of the gateway clock divider.
//   cfg_v     write valid (master -> slave)
//   cfg_chan  target channel
//   cfg_div   new divide value, 0 disables the channel
//   cfg_ready target channel has an empty pending slot (slave -> master)
//   cfg_error one-cycle pulse after an accepted write of divide 1
interface bsg_gateway_clk_div_multi_if
  import bsg_gateway_clk_pkg::*;
#(
  parameter int num_channels_p = 4,
  parameter int div_width_p    = 8
);

  localparam int chan_width_lp = int'(chan_width(num_channels_p));

  logic                     cfg_v;
  logic [chan_width_lp-1:0] cfg_chan;
  logic [div_width_p-1:0]   cfg_div;
  logic                     cfg_ready;
  logic                     cfg_error;

  modport master (output cfg_v, cfg_chan, cfg_div, input  cfg_ready, cfg_error);
  modport slave  (input  cfg_v, cfg_chan, cfg_div, output cfg_ready, cfg_error);

endinterface

// File: rtl/bsg_gateway_clk_div_multi_chan.sv
// One divided-clock channel.
//   clk_i/reset_i  source clock, synchronous active-high reset
//   en             channel may run this cycle (next value of locked_o)
//   align          restart the count at a rising edge
//   wr_v/wr_div    store a new divide into the pending slot
//   ready          pending slot empty
//   clk/strobe     registered divided clock and its rising-edge strobe
// A pending divide only takes effect where the count wraps to zero (or at
// once while the channel is idle), so every period under the new divide
// starts with a full high phase.
module bsg_gateway_clk_div_chan
  import bsg_gateway_clk_pkg::*;
#(
  parameter int div_width_p = 8,
  parameter int init_div_p  = 4
)
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en,
  input  logic                   align,
  input  logic                   wr_v,
  input  logic [div_width_p-1:0] wr_div,
  output logic                   ready,
  output logic                   clk,
  output logic                   strobe
);

  localparam logic [div_width_p-1:0] one_lp      = {{(div_width_p-1){1'b0}}, 1'b1};
  localparam logic [div_width_p-1:0] disable_lp  = div_width_p'(div_disable_lp);
  localparam logic [div_width_p-1:0] init_div_lp = div_width_p'(init_div_p);

  logic [div_width_p-1:0] div_r;
  logic [div_width_p-1:0] pend_r;
  logic                   pend_v_r;
  logic [div_width_p-1:0] cnt_r;
  logic                   run_r;
  logic                   clk_r;
  logic                   strobe_r;

  logic                   start_s;
  logic                   align_s;
  logic                   last_s;
  logic                   wrap_s;
  logic                   apply_s;
  logic [div_width_p-1:0] div_eff_s;
  logic [div_width_p-1:0] cnt_n_s;
  logic                   clk_n_s;
  logic                   strobe_n_s;

  // Next count, apply decision and next output values.
  always_comb begin
    start_s    = 1'b0;
    align_s    = 1'b0;
    last_s     = 1'b0;
    wrap_s     = 1'b0;
    apply_s    = 1'b0;
    div_eff_s  = div_r;
    cnt_n_s    = '0;
    clk_n_s    = 1'b0;
    strobe_n_s = 1'b0;

    // run_r is the previous en, so this marks the first running cycle.
    start_s = en & ~run_r;
    // Alignment only counts while the channel was already running.
    align_s = align & run_r & en;

    if (div_r == disable_lp) begin
      last_s = 1'b1;
    end else begin
      last_s = (cnt_r == (div_r - one_lp));
    end

    wrap_s  = start_s | align_s | last_s;
    apply_s = pend_v_r & (~en | wrap_s);

    if (apply_s) begin
      div_eff_s = pend_r;
    end else begin
      div_eff_s = div_r;
    end

    if (en & ~wrap_s) begin
      cnt_n_s = cnt_r + one_lp;
    end else begin
      cnt_n_s = '0;
    end

    if (en & (div_eff_s != disable_lp)) begin
      clk_n_s    = (32'(cnt_n_s) < high_phase_len(32'(div_eff_s)));
      strobe_n_s = (cnt_n_s == '0);
    end else begin
      clk_n_s    = 1'b0;
      strobe_n_s = 1'b0;
    end
  end

  // Channel state: divide, pending slot, counter and output flops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_r    <= init_div_lp;
      pend_r   <= '0;
      pend_v_r <= 1'b0;
      cnt_r    <= '0;
      run_r    <= 1'b0;
      clk_r    <= 1'b0;
      strobe_r <= 1'b0;
    end else begin
      run_r    <= en;
      cnt_r    <= cnt_n_s;
      clk_r    <= clk_n_s;
      strobe_r <= strobe_n_s;
      if (apply_s) begin
        div_r <= pend_r;
      end else begin
        div_r <= div_r;
      end
      // A write can only arrive with the slot empty, so it never races an apply.
      if (wr_v) begin
        pend_r   <= wr_div;
        pend_v_r <= 1'b1;
      end else if (apply_s) begin
        pend_r   <= pend_r;
        pend_v_r <= 1'b0;
      end else begin
        pend_r   <= pend_r;
        pend_v_r <= pend_v_r;
      end
    end
  end

  assign ready  = ~pend_v_r;
  assign clk    = clk_r;
  assign strobe = strobe_r;

endmodule

// File: rtl/bsg_gateway_clk_div_multi.sv
// Runtime-programmable multi-channel clock divider with a lock sequencer.
//   clk_i         fast gateway clock (PLL output), the only clock
//   reset_i       synchronous active-high reset
//   pll_locked_i  asynchronous PLL LOCKED, synchronized here
//   align_i       one-cycle pulse restarting all running channels together
//   cfg_if        config write port (valid/ready, error pulse)
//   clk_o         divided clocks, one per channel, registered
//   strobe_o      one-cycle pulse on each clk_o rising edge, registered
//   locked_o      lock has been stable long enough; channels are running
// Channels see the next value of locked_o as their enable so that the first
// locked cycle already carries an aligned rising edge on every channel.
module bsg_gateway_clk_div_multi
  import bsg_gateway_clk_pkg::*;
#(
  parameter int num_channels_p = 4,
  parameter int div_width_p    = 8,
  parameter int init_div_p     = 4,
  parameter int lock_wait_p    = 1024
)
(
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       pll_locked_i,
  input  logic                       align_i,
  bsg_gateway_clk_div_multi_if.slave cfg_if,
  output logic [num_channels_p-1:0]  clk_o,
  output logic [num_channels_p-1:0]  strobe_o,
  output logic                       locked_o
);

  localparam int lock_cnt_width_lp = $clog2(lock_wait_p + 1);
  localparam logic [lock_cnt_width_lp-1:0] lock_wait_lp  = lock_cnt_width_lp'(lock_wait_p);
  localparam logic [lock_cnt_width_lp-1:0] lock_one_lp   = lock_cnt_width_lp'(1);
  localparam logic [div_width_p-1:0]       div_one_lp    = {{(div_width_p-1){1'b0}}, 1'b1};

  logic [sync_depth_lp-1:0]     sync_r;
  logic                         lk_s;
  logic [lock_cnt_width_lp-1:0] lock_cnt_r;
  logic [lock_cnt_width_lp-1:0] lock_cnt_n_s;
  logic                         locked_r;
  logic                         locked_n_s;
  logic                         error_r;

  logic                         chan_ok_s;
  logic                         ready_s;
  logic                         accept_s;
  logic                         div_is_one_s;
  logic [num_channels_p-1:0]    wr_v_s;
  logic [num_channels_p-1:0]    chan_ready_s;

  assign lk_s = sync_r[sync_depth_lp-1];

  // Lock counter: saturates at lock_wait_p while synced lock holds, clears on loss.
  always_comb begin
    lock_cnt_n_s = lock_cnt_r;
    locked_n_s   = 1'b0;
    if (lk_s) begin
      if (lock_cnt_r != lock_wait_lp) begin
        lock_cnt_n_s = lock_cnt_r + lock_one_lp;
      end else begin
        lock_cnt_n_s = lock_cnt_r;
      end
      locked_n_s = (lock_cnt_r == lock_wait_lp);
    end else begin
      lock_cnt_n_s = '0;
      locked_n_s   = 1'b0;
    end
  end

  // Config demux: ready of the addressed channel, acceptance and divide-1 rejection.
  always_comb begin
    chan_ok_s    = 1'b0;
    ready_s      = 1'b0;
    accept_s     = 1'b0;
    div_is_one_s = 1'b0;
    wr_v_s       = '0;

    chan_ok_s = (32'(cfg_if.cfg_chan) < 32'(num_channels_p));
    if (chan_ok_s) begin
      ready_s = chan_ready_s[cfg_if.cfg_chan];
    end else begin
      ready_s = 1'b0;
    end
    accept_s     = cfg_if.cfg_v & ready_s;
    div_is_one_s = (cfg_if.cfg_div == div_one_lp);
    for (int i = 0; i < num_channels_p; i++) begin
      wr_v_s[i] = accept_s & ~div_is_one_s & (32'(cfg_if.cfg_chan) == 32'(i));
    end
  end

  // Lock synchronizer, lock counter, locked flag and error pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_r     <= '0;
      lock_cnt_r <= '0;
      locked_r   <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      sync_r     <= {sync_r[sync_depth_lp-2:0], pll_locked_i};
      lock_cnt_r <= lock_cnt_n_s;
      locked_r   <= locked_n_s;
      error_r    <= accept_s & div_is_one_s;
    end
  end

  for (genvar g = 0; g < num_channels_p; g++) begin : g_chan
    bsg_gateway_clk_div_chan #(
      .div_width_p (div_width_p),
      .init_div_p  (init_div_p)
    ) u_chan (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en      (locked_n_s),
      .align   (align_i),
      .wr_v    (wr_v_s[g]),
      .wr_div  (cfg_if.cfg_div),
      .ready   (chan_ready_s[g]),
      .clk     (clk_o[g]),
      .strobe  (strobe_o[g])
    );
  end

  assign locked_o         = locked_r;
  assign cfg_if.cfg_ready = ready_s;
  assign cfg_if.cfg_error = error_r;

endmodule

// File: tb/tb_bsg_gateway_clk_div_multi.sv
// Directed bench for the gateway multi-channel clock divider.
module tb_bsg_gateway_clk_div_multi;
  import bsg_gateway_clk_pkg::*;

  localparam int num_ch_lp = 4;
  localparam int lw_lp     = 16;

  logic       clk;
  logic       reset_i;
  logic       pll_locked_i;
  logic       align_i;
  logic [3:0] clk_o;
  logic [3:0] strobe_o;
  logic       locked_o;

  int n_checks = 0;
  int n_pass   = 0;

  bsg_gateway_clk_div_multi_if #(.num_channels_p(num_ch_lp), .div_width_p(8)) cfg_if ();

  bsg_gateway_clk_div_multi #(
    .num_channels_p (num_ch_lp),
    .div_width_p    (8),
    .init_div_p     (4),
    .lock_wait_p    (lw_lp)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .pll_locked_i (pll_locked_i),
    .align_i      (align_i),
    .cfg_if       (cfg_if),
    .clk_o        (clk_o),
    .strobe_o     (strobe_o),
    .locked_o     (locked_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; return at the following falling edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_cfg(input logic v, input chan_idx_t ch, input div_t d);
    cfg_if.cfg_v    = v;
    cfg_if.cfg_chan = ch;
    cfg_if.cfg_div  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] seq_clk;
    logic [9:0] seq_stb;
    logic [5:0] seq0;
    logic [6:0] seq3;
    logic       acc;
    int         first_common;

    reset_i      = 1'b1;
    pll_locked_i = 1'b0;
    align_i      = 1'b0;
    set_cfg(1'b0, 2'd0, 8'd0);
    @(negedge clk);
    tick(2);

    check("rst_locked", 32'(locked_o), 32'd0);
    check("rst_clk",    32'(clk_o),    32'd0);
    check("rst_strobe", 32'(strobe_o), 32'd0);
    check("rst_ready",  32'(cfg_if.cfg_ready), 32'd1);
    check("rst_error",  32'(cfg_if.cfg_error), 32'd0);

    // Lock sequence: locked_o on the 19th edge after the raise.
    reset_i      = 1'b0;
    pll_locked_i = 1'b1;
    tick(18);
    check("lock_early", 32'(locked_o), 32'd0);
    tick(1);
    check("lock_on",     32'(locked_o), 32'd1);
    check("lock_clk",    32'(clk_o),    32'hF);
    check("lock_strobe", 32'(strobe_o), 32'hF);
    tick(1);
    check("d4_c1_clk", 32'(clk_o),    32'hF);
    check("d4_c1_stb", 32'(strobe_o), 32'h0);
    tick(1);
    check("d4_c2_clk", 32'(clk_o), 32'h0);
    tick(2);
    check("d4_c0_clk", 32'(clk_o),    32'hF);
    check("d4_c0_stb", 32'(strobe_o), 32'hF);

    // ch1 <- 5 written mid-period; slot stays full until the wrap.
    set_cfg(1'b1, 2'd1, 8'd5);
    check("ch1_ready_idle", 32'(cfg_if.cfg_ready), 32'd1);
    tick(1);
    cfg_if.cfg_v = 1'b0;
    check("ch1_ready_pend1", 32'(cfg_if.cfg_ready), 32'd0);
    tick(2);
    check("ch1_ready_pend3", 32'(cfg_if.cfg_ready), 32'd0);
    tick(1);
    check("ch1_ready_apply", 32'(cfg_if.cfg_ready), 32'd1);
    check("ch1_apply_clk",   32'(clk_o[1]),    32'd1);
    check("ch1_apply_stb",   32'(strobe_o[1]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seq_clk[i] = clk_o[1];
      seq_stb[i] = strobe_o[1];
    end
    check("ch1_d5_clk_seq", 32'(seq_clk), 32'(10'b1001110011));
    check("ch1_d5_stb_seq", 32'(seq_stb), 32'(10'b1000010000));

    // ch2 <- 1 is rejected; ch2 keeps D=4 (now at count 2).
    set_cfg(1'b1, 2'd2, 8'd1);
    tick(1);
    cfg_if.cfg_v = 1'b0;
    check("err_pulse",    32'(cfg_if.cfg_error), 32'd1);
    check("err_no_pend",  32'(cfg_if.cfg_ready), 32'd1);
    tick(1);
    check("err_clear",    32'(cfg_if.cfg_error), 32'd0);
    check("ch2_d4_stb",   32'(strobe_o[2]), 32'd1);

    // ch2 <- 0: stays low from its wrap onward.
    set_cfg(1'b1, 2'd2, 8'd0);
    tick(1);
    cfg_if.cfg_v = 1'b0;
    check("ch2_pend_clk",   32'(clk_o[2]), 32'd1);
    check("ch2_pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
    tick(3);
    check("ch2_off_clk",   32'(clk_o[2]),    32'd0);
    check("ch2_off_stb",   32'(strobe_o[2]), 32'd0);
    check("ch2_off_ready", 32'(cfg_if.cfg_ready), 32'd1);
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      acc = acc | clk_o[2] | strobe_o[2];
    end
    check("ch2_off_quiet", 32'(acc), 32'd0);

    // ch0 <- 3, ch3 <- 7, then align.
    set_cfg(1'b1, 2'd0, 8'd3);
    tick(1);
    set_cfg(1'b1, 2'd3, 8'd7);
    tick(1);
    cfg_if.cfg_v = 1'b0;
    tick(8);
    align_i = 1'b1;
    tick(1);
    align_i = 1'b0;
    check("align_stb", 32'(strobe_o), 32'hB);
    check("align_clk", 32'(clk_o),    32'hB);
    first_common = 0;
    for (int i = 1; i <= 21; i++) begin
      tick(1);
      if (i <= 6) seq0[i-1] = clk_o[0];
      if (i <= 7) seq3[i-1] = clk_o[3];
      if (first_common == 0 && strobe_o[0] && strobe_o[3]) first_common = i;
    end
    check("ch0_d3_seq",    32'(seq0), 32'(6'b101101));
    check("ch3_d7_seq",    32'(seq3), 32'(7'b1000111));
    check("common_rise",   32'(first_common), 32'd21);

    // Loss of lock, then relock with an aligned restart.
    pll_locked_i = 1'b0;
    tick(2);
    check("drop_still_locked", 32'(locked_o), 32'd1);
    tick(1);
    check("drop_locked", 32'(locked_o), 32'd0);
    check("drop_clk",    32'(clk_o),    32'h0);
    check("drop_stb",    32'(strobe_o), 32'h0);
    tick(3);
    check("drop_frozen", 32'(clk_o), 32'h0);
    pll_locked_i = 1'b1;
    tick(18);
    check("relock_early", 32'(locked_o), 32'd0);
    tick(1);
    check("relock_on",  32'(locked_o), 32'd1);
    check("relock_clk", 32'(clk_o),    32'hB);
    check("relock_stb", 32'(strobe_o), 32'hB);

    // Reset with a pending write on ch1.
    set_cfg(1'b1, 2'd1, 8'd9);
    tick(1);
    cfg_if.cfg_v = 1'b0;
    check("rst2_pend", 32'(cfg_if.cfg_ready), 32'd0);
    reset_i = 1'b1;
    tick(1);
    check("rst2_locked", 32'(locked_o), 32'd0);
    check("rst2_clk",    32'(clk_o),    32'h0);
    check("rst2_stb",    32'(strobe_o), 32'h0);
    check("rst2_ready",  32'(cfg_if.cfg_ready), 32'd1);
    reset_i = 1'b0;
    tick(18);
    check("rst2_lock_early", 32'(locked_o), 32'd0);
    tick(1);
    check("rst2_lock_on", 32'(locked_o), 32'd1);
    check("rst2_clk_all", 32'(clk_o),    32'hF);
    tick(2);
    check("rst2_d4_low",  32'(clk_o),    32'h0);
    tick(2);
    check("rst2_d4_stb",  32'(strobe_o), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
